picosoc_iomem_arbiter: RTL

Two-master arbiter for the PicoSoC iomem peripheral bus. The PicoRV32 CPU (master 0) and a secondary bus master (master 1, e.g. a disk/DMA mover) share the existing address-decoded slave fabric (SRAM, UART, GPIO, SDRAM, SD card, A2FPGA, disk, slots). The block sits between both masters and the decoder/ready mux, arbitrates per transaction with round-robin fairness, and optionally terminates transactions to unresponsive slaves.

---
 rtl/picosoc_iomem_arbiter_if.sv | 21 ++
 rtl/picosoc_iomem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/picosoc_iomem_arbiter_if.sv
// iomem request/response bundle.
// The master drives the request fields; the slave returns rdata/ready.
interface picosoc_iomem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid, instr, wstrb, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  valid, instr, wstrb, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/picosoc_iomem_arbiter.sv
// Two-master round-robin arbiter in front of the PicoSoC iomem fabric.
// Define PICOSOC_ARB_TIMEOUT_EN to terminate transactions to stalled slaves.
module picosoc_iomem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           resetn,
  picosoc_iomem_arbiter_if.slave         m0,
  picosoc_iomem_arbiter_if.slave         m1,
  picosoc_iomem_arbiter_if.master        s,
  output logic [1:0]                     grant_o,
  output logic                           timeout_o,
  input  logic                           err_clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        last_grant;
  logic        last_grant_nx;
  logic        own1;
  logic        own_valid;
  logic        done;
  logic [31:0] rsp;
  logic        expire;
  logic        tmo_set;
  logic        unused_m1_instr;

  assign unused_m1_instr = m1.instr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

`ifdef PICOSOC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          tmo_q;

  assign expire    = (cnt == CW'(TIMEOUT_CYCLES)) && !s.ready;
  assign timeout_o = tmo_q;

  // Clearing while idle guarantees a fresh count on every grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (!s.ready) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_q <= 1'b0;
    end else if (tmo_set) begin
      tmo_q <= 1'b1;
    end else if (err_clr_i) begin
      tmo_q <= 1'b0;
    end
  end
`else
  localparam int UNUSED_TMO_CYCLES = TIMEOUT_CYCLES;

  logic [31:0] unused_cfg;

  assign unused_cfg = {UNUSED_TMO_CYCLES[29:0], err_clr_i, tmo_set};
  assign expire     = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    tmo_set       = 1'b0;
    grant_o       = 2'b00;
    own1          = 1'b0;
    own_valid     = 1'b0;
    done          = 1'b0;
    rsp           = '0;
    s.valid       = 1'b0;
    s.instr       = 1'b0;
    s.wstrb       = '0;
    s.addr        = '0;
    s.wdata       = '0;

    unique case (state)
      IDLE: begin
        unique case (1'b1)
          m0.valid && m1.valid:
            state_nx = last_grant ? BUSY0 : BUSY1;
          m0.valid && !m1.valid:
            state_nx = BUSY0;
          !m0.valid && m1.valid:
            state_nx = BUSY1;
          default:
            state_nx = IDLE;
        endcase
      end
      BUSY0: begin
        grant_o   = 2'b01;
        own_valid = m0.valid;
        s.valid   = m0.valid;
        s.instr   = m0.instr;
        s.wstrb   = m0.wstrb;
        s.addr    = m0.addr;
        s.wdata   = m0.wdata;
      end
      BUSY1: begin
        grant_o   = 2'b10;
        own1      = 1'b1;
        own_valid = m1.valid;
        s.valid   = m1.valid;
        s.wstrb   = m1.wstrb;
        s.addr    = m1.addr;
        s.wdata   = m1.wdata;
      end
      default: state_nx = IDLE;
    endcase

    // A real slave response beats an expiring counter on the same cycle.
    if (state != IDLE) begin
      unique case (1'b1)
        !own_valid: begin
          state_nx = IDLE;
        end
        own_valid && s.ready: begin
          done          = 1'b1;
          rsp           = s.rdata;
          state_nx      = IDLE;
          last_grant_nx = own1;
        end
        own_valid && !s.ready && expire: begin
          s.valid       = 1'b0;
          done          = 1'b1;
          rsp           = 32'hFFFF_FFFF;
          tmo_set       = 1'b1;
          state_nx      = IDLE;
          last_grant_nx = own1;
        end
        default: ;
      endcase
    end
  end

  assign m0.ready = done && !own1;
  assign m1.ready = done && own1;
  assign m0.rdata = (done && !own1) ? rsp : '0;
  assign m1.rdata = (done && own1) ? rsp : '0;

endmodule
